// File: rtl/riscv_stream_pkg.sv
// Shared definitions for the producer-side and consumer-side RISC-V stream buffers.
package riscv_stream_pkg;

  // Producer skid buffer: bit 1 is ready_upward, bit 0 is val_out, so both
  // outputs come straight off the state flops. 2'b00 is unused.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b10,
    ST_BUSY  = 2'b11,
    ST_FULL  = 2'b01
  } prod_state_e;

  // Consumer-side buffer states (transfer / receive).
  typedef enum logic {
    CS_TR = 1'b0,
    CS_RE = 1'b1
  } cons_state_e;

endpackage

// File: rtl/producer2riscv_if.sv
// Stream handshake between an upstream operator, the producer buffer and the RISC-V side.
interface producer2riscv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] din;
  logic                  val_in;
  logic                  ready_upward;
  logic [DATA_WIDTH-1:0] dout;
  logic                  val_out;
  logic                  ready_downward;

  modport slave (
    input  din, val_in, ready_downward,
    output ready_upward, dout, val_out
  );

  modport master (
    output din, val_in, ready_downward,
    input  ready_upward, dout, val_out
  );
endinterface

// File: rtl/producer2riscv.sv
// Two-entry skid buffer feeding the RISC-V side, with a delivered-word counter.
// All outputs are flop-driven; nothing combinational reaches them from inputs.
module producer2riscv
  import riscv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  producer2riscv_if.slave      bus,
  output logic [CNT_WIDTH-1:0] word_count
);

  prod_state_e           state, state_nxt;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  ut, dt;
  logic                  load_main_din, load_main_skid, load_skid;

  assign bus.ready_upward = state[1];
  assign bus.val_out      = state[0];
  assign bus.dout         = main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    ut             = bus.val_in & state[1];
    dt             = state[0] & bus.ready_downward;
    state_nxt      = ST_EMPTY;
    load_main_din  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_main_din = ut;
        state_nxt     = ut ? ST_BUSY : ST_EMPTY;
      end
      ST_BUSY: begin
        if (ut && dt) begin
          load_main_din = 1'b1;
          state_nxt     = ST_BUSY;
        end else if (ut) begin
          load_skid = 1'b1;
          state_nxt = ST_FULL;
        end else if (dt) begin
          state_nxt = ST_EMPTY;
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_FULL: begin
        load_main_skid = dt;
        state_nxt      = dt ? ST_BUSY : ST_FULL;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_din)       main_q <= bus.din;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  word_count <= '0;
    else if (dt) word_count <= word_count + CNT_WIDTH'(1);
  end

endmodule
